// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial add/subtract unit: FSM states and
// the digit-counter width helper.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width for K digit cycles: clog2(K), never less than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/serial_addsub_digit_addsub.sv
// Combinational D-bit add/subtract slice; in subtract mode cin/cout are
// borrow-in/borrow-out.
module digit_addsub #(
    parameter int unsigned D = 4
) (
    input  logic [D-1:0] i_a,
    input  logic [D-1:0] i_b,
    input  logic         i_cin,
    input  logic         i_sub,
    output logic [D-1:0] o_s,
    output logic         o_cout
);

    logic [D:0] w_c;

    always_comb begin
        w_c    = '0;
        o_s    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < int'(D); i++) begin
            o_s[i] = i_a[i] ^ i_b[i] ^ w_c[i];
            if (i_sub) begin
                w_c[i+1] = (~i_a[i] & i_b[i]) | (~i_a[i] & w_c[i]) | (i_b[i] & w_c[i]);
            end else begin
                w_c[i+1] = (i_a[i] & i_b[i]) | (i_a[i] & w_c[i]) | (i_b[i] & w_c[i]);
            end
        end
    end

    assign o_cout = w_c[D];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial N-bit add/subtract unit: one D-bit digit per clock, LSB first,
// with valid/ready handshakes and carry/borrow, overflow and zero flags.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int unsigned K  = (D == 0) ? 1 : N / D;
    localparam int unsigned CW = cnt_width(K);

    if (N < 1 || D < 1 || D > N || (N % D) != 0) begin : g_param_check
        $error("serial_addsub: illegal N=%0d / D=%0d", N, D);
    end

    state_t          r_state;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_sub;
    logic            r_carry;
    logic            r_a_msb;
    logic            r_b_msb;

    logic [D-1:0]    w_s;
    logic            w_cout;
    logic [N-1:0]    w_acc_next;
    logic            w_last;
    logic            w_ovf_next;

    digit_addsub #(.D(D)) u_digit (
        .i_a    (r_a[D-1:0]),
        .i_b    (r_b[D-1:0]),
        .i_cin  (r_carry),
        .i_sub  (r_sub),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    // New digit enters at the top; after K shifts the accumulator is aligned.
    assign w_acc_next = (r_acc >> D) | (N'(w_s) << (N - D));
    assign w_last     = (r_cnt == CW'(K - 1));
    assign w_ovf_next = (r_sub ? (r_a_msb != r_b_msb) : (r_a_msb == r_b_msb))
                        && (w_acc_next[N-1] != r_a_msb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sub     <= 1'b0;
            r_carry   <= 1'b0;
            r_a_msb   <= 1'b0;
            r_b_msb   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_sub    <= sub;
                        r_a_msb  <= a[N-1];
                        r_b_msb  <= b[N-1];
                        r_cnt    <= '0;
                        r_carry  <= 1'b0;
                        r_acc    <= '0;
                        in_ready <= 1'b0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> D;
                    r_b     <= r_b >> D;
                    r_carry <= w_cout;
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        result    <= w_acc_next;
                        cout      <= w_cout;
                        ovf       <= w_ovf_next;
                        zero      <= (w_acc_next == '0);
                        out_valid <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed cases on a D=4 instance plus random
// operands on D=1/4/8/16 instances, all checked against an arithmetic model.
module tb_serial_addsub;

    typedef struct packed {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s inst%0d @cyc %0d: got 0x%0h expected 0x%0h",
                         name, inst, cyc, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib,
                                   input logic isub);
        exp_t e;
        int ua = int'(ia);
        int ub = int'(ib);
        int sa = int'($signed(ia));
        int sb = int'($signed(ib));
        int r;
        int s;
        if (isub) begin
            r      = ua - ub;
            s      = sa - sb;
            e.cout = (ua < ub);
        end else begin
            r      = ua + ub;
            s      = sa + sb;
            e.cout = (r > 65535);
        end
        e.res  = 16'(r);
        e.ovf  = (s > 32767) || (s < -32768);
        e.zero = (e.res == 16'h0000);
        return e;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            4:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int unsigned DV = (g == 0 || g == 2) ? 4 : (g == 1) ? 1 : (g == 3) ? 8 : 16;
        localparam int unsigned KV = 16 / DV;

        logic        rst_n;
        logic        in_valid;
        logic        in_ready;
        logic        sub;
        logic        out_valid;
        logic        out_ready;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] result;
        logic        exp_ov;
        exp_t        q[$];
        int          acc_q[$];

        serial_addsub #(.N(16), .D(DV)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .result    (result),
            .cout      (cout),
            .ovf       (ovf),
            .zero      (zero)
        );

        // Every cycle: handshake state and, when due, the result against the model.
        always @(negedge clk) begin
            if (!rst_n) begin
                chk("rst_outputs", g, 32'({out_valid, result, cout, ovf, zero}), 32'd0);
                q.delete();
                acc_q.delete();
            end else begin
                exp_ov = 1'b0;
                if (q.size() != 0) exp_ov = (cyc - acc_q[0]) >= int'(KV);
                chk("in_ready", g, 32'(in_ready), 32'(q.size() == 0));
                chk("out_valid", g, 32'(out_valid), 32'(exp_ov));
                if (exp_ov) begin
                    chk("result_flags", g, 32'({result, cout, ovf, zero}), 32'(q[0]));
                    if (out_valid && out_ready) begin
                        void'(q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    q.push_back(model(a, b, sub));
                    acc_q.push_back(cyc + 1);
                end
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic do_reset();
            rst_n    = 1'b0;
            in_valid = 1'b0;
            a        = '0;
            b        = '0;
            sub      = 1'b0;
            step();
            step();
            rst_n = 1'b1;
            step();
        endtask

        task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic isub);
            int n = 0;
            while (!in_ready && n < 200) begin
                step();
                n++;
            end
            if (!in_ready) chk("in_ready_wait", g, 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            a        = ia;
            b        = ib;
            sub      = isub;
            step();
            in_valid = 1'b0;
        endtask

        task automatic wait_idle();
            int n = 0;
            while (!in_ready && n < 400) begin
                step();
                n++;
            end
            chk("drain", g, 32'({in_ready, 8'(q.size())}), 32'h100);
        endtask

        if (g == 0) begin : g_dir
            logic dir_ordy = 1'b0;
            assign out_ready = dir_ordy;

            task automatic wait_ov(input logic [18:0] lit);
                int n = 0;
                while (!out_valid && n < 50) begin
                    step();
                    n++;
                end
                chk("dir_latency", g, 32'(n), 32'(KV));
                chk("dir_value", g, 32'({result, cout, ovf, zero}), 32'(lit));
            endtask

            task automatic run_dir(input logic [15:0] ia, input logic [15:0] ib,
                                   input logic isub, input logic [18:0] lit);
                issue(ia, ib, isub);
                wait_ov(lit);
                dir_ordy = 1'b1;
                step();
                dir_ordy = 1'b0;
                chk("dir_release", g, 32'({out_valid, in_ready}), 32'b01);
            endtask

            initial begin
                do_reset();
                chk("post_reset", g, 32'({in_ready, out_valid, result, cout, ovf, zero}), 32'h100000);
                run_dir(16'h1234, 16'h0234, 1'b1, {16'h1000, 3'b000});
                run_dir(16'h0000, 16'h0001, 1'b1, {16'hFFFF, 3'b100});
                run_dir(16'h7FFF, 16'hFFFF, 1'b1, {16'h8000, 3'b110});
                run_dir(16'hFFFF, 16'h0001, 1'b0, {16'h0000, 3'b101});
                run_dir(16'h7FFF, 16'h0001, 1'b0, {16'h8000, 3'b010});

                // Backpressure: result held, new operands ignored.
                issue(16'h1234, 16'h1111, 1'b0);
                wait_ov({16'h2345, 3'b000});
                repeat (5) begin
                    in_valid = 1'b1;
                    a        = 16'($urandom);
                    b        = 16'($urandom);
                    sub      = 1'($urandom);
                    step();
                    chk("bp_hold", g, 32'({out_valid, in_ready, result, cout, ovf, zero}),
                        32'({2'b10, 16'h2345, 3'b000}));
                end
                in_valid = 1'b0;
                dir_ordy = 1'b1;
                step();
                dir_ordy = 1'b0;
                chk("bp_release", g, 32'({out_valid, in_ready}), 32'b01);

                // Reset after digit 1 of a running operation.
                issue(16'hABCD, 16'h1234, 1'b1);
                step();
                step();
                rst_n = 1'b0;
                #1;
                chk("rst_abort", g, 32'({out_valid, result, cout, ovf, zero}), 32'd0);
                step();
                step();
                rst_n = 1'b1;
                step();
                chk("rst_release", g, 32'({out_valid, in_ready, result, cout, ovf, zero}),
                    32'({2'b01, 19'd0}));
                run_dir(16'h0005, 16'h0003, 1'b1, {16'h0002, 3'b000});
                wait_idle();
                n_done++;
            end
        end else begin : g_rnd
            logic rnd_ordy = 1'b0;
            assign out_ready = rnd_ordy;

            always begin
                @(posedge clk);
                #1;
                rnd_ordy = ($urandom_range(3) != 0);
            end

            initial begin
                do_reset();
                for (int i = 0; i < 2000; i++) begin
                    if ($urandom_range(3) == 0) step();
                    issue(rnd16(), rnd16(), 1'(i & 1));
                    a   = 16'($urandom);
                    b   = 16'($urandom);
                    sub = 1'($urandom);
                end
                wait_idle();
                n_done++;
            end
        end
    end

    initial begin
        int n = 0;
        while (n_done < 5 && n < 90000) begin
            @(posedge clk);
            n++;
        end
        if (n_done < 5) chk("all_done", -1, 32'(n_done), 32'd5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
